// File: rtl/shiftout_chain.sv
// Serial shift-out engine for daisy-chained 74HC595-style registers.
// Optional readback of the chain tail: define SHIFTOUT_CHAIN_CAPTURE_EN.
module shiftout_chain #(
  parameter int WIDTH     = 16,
  parameter int CLK_DIV   = 1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] data_in,
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
  input  logic             sdi_in,
  output logic [WIDTH-1:0] rx_data_out,
`endif
  output logic             busy_out,
  output logic             done_out,
  output logic             clk_out,
  output logic             data_out,
  output logic             latch_out
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             lat_q, lat_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
  logic [WIDTH-1:0] rxsh_q, rxsh_d;
  logic [WIDTH-1:0] rx_q, rx_d;
`endif

  logic [WIDTH-1:0] sh_next;
  logic             bit_next;

  // Next word position and the bit that follows the current one.
  always_comb begin
    if (LSB_FIRST) begin
      sh_next  = {1'b0, sh_q[WIDTH-1:1]};
      bit_next = sh_q[1];
    end else begin
      sh_next  = {sh_q[WIDTH-2:0], 1'b0};
      bit_next = sh_q[WIDTH-2];
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    lat_d   = lat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
    rxsh_d  = rxsh_q;
    rx_d    = rx_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_in) begin
          sh_d    = data_in;
          sdo_d   = LSB_FIRST ? data_in[0] : data_in[WIDTH-1];
          lat_d   = 1'b0;
          busy_d  = 1'b1;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = '0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = S_HIGH;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
          // Sample alongside the rising serial clock.
          if (LSB_FIRST)
            rxsh_d = {sdi_in, rxsh_q[WIDTH-1:1]};
          else
            rxsh_d = {rxsh_q[WIDTH-2:0], sdi_in};
`endif
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = 1'b0;
          if (bit_q < BIT_LAST) begin
            bit_d   = bit_q + 1'b1;
            sh_d    = sh_next;
            sdo_d   = bit_next;
            state_d = S_LOW;
          end else begin
            bit_d   = '0;
            sdo_d   = 1'b0;
            lat_d   = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
            rx_d    = rxsh_q;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      lat_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
      rxsh_q  <= '0;
      rx_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      lat_q   <= lat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
      rxsh_q  <= rxsh_d;
      rx_q    <= rx_d;
`endif
    end
  end

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign clk_out   = sclk_q;
  assign data_out  = sdo_q;
  assign latch_out = lat_q;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
  assign rx_data_out = rx_q;
`endif

endmodule

// File: tb/tb_shiftout_chain.sv
// Directed bench for shiftout_chain: two instances, 16b/div1/MSB and 8b/div3/LSB.
// Capture readback is exercised when SHIFTOUT_CHAIN_CAPTURE_EN is defined.
module tb_shiftout_chain;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        st0 = 1'b0;
  logic [15:0] d0  = '0;
  logic        busy0, done0, sclk0, sdo0, lat0;
  logic        st1 = 1'b0;
  logic [7:0]  d1  = '0;
  logic        busy1, done1, sclk1, sdo1, lat1;
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
  logic [15:0] rx0;
  logic [7:0]  rx1;
  logic [15:0] chain = '0;
  logic        sdi0;
  logic        sdi1 = 1'b0;
  assign sdi0 = chain[15];
  always @(posedge sclk0) chain <= {chain[14:0], sdo0};
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  shiftout_chain #(.WIDTH(16), .CLK_DIV(1), .LSB_FIRST(1'b0)) u0 (
    .clk_in(clk), .reset_in(rst), .start_in(st0), .data_in(d0),
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
    .sdi_in(sdi0), .rx_data_out(rx0),
`endif
    .busy_out(busy0), .done_out(done0), .clk_out(sclk0),
    .data_out(sdo0), .latch_out(lat0)
  );

  shiftout_chain #(.WIDTH(8), .CLK_DIV(3), .LSB_FIRST(1'b1)) u1 (
    .clk_in(clk), .reset_in(rst), .start_in(st1), .data_in(d1),
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
    .sdi_in(sdi1), .rx_data_out(rx1),
`endif
    .busy_out(busy1), .done_out(done1), .clk_out(sclk1),
    .data_out(sdo1), .latch_out(lat1)
  );

  // Downstream view: bits seen at each serial clock rise, in arrival order.
  logic [15:0] mon0  = '0;
  int          rise0 = 0;
  logic        hb0   = 1'b0;
  int          viol0 = 0;
  logic [7:0]  mon1  = '0;
  int          rise1 = 0;
  logic        hb1   = 1'b0;
  int          viol1 = 0;

  always @(posedge sclk0) begin
    mon0  <= {mon0[14:0], sdo0};
    rise0 <= rise0 + 1;
    hb0   <= sdo0;
  end
  always @(posedge sclk1) begin
    mon1  <= {mon1[6:0], sdo1};
    rise1 <= rise1 + 1;
    hb1   <= sdo1;
  end
  always @(negedge clk) begin
    if (sclk0 && sdo0 !== hb0) viol0 <= viol0 + 1;
    if (sclk1 && sdo1 !== hb1) viol1 <= viol1 + 1;
  end

  // Transfer driver for u0; optional extra start pulses at given cycles.
  task automatic run0(input logic [15:0] w, input int mid_n,
                      input logic [15:0] mid_w, input int late_n,
                      input logic [15:0] late_w,
                      output int n, output int low, output int bsy);
    @(negedge clk);
    d0  = w;
    st0 = 1'b1;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    n = 0; low = 0; bsy = 0;
    while (!done0 && n < 400) begin
      if (!lat0) low++;
      if (busy0) bsy++;
      if (n == 0) d0 = ~w;
      if (n == mid_n) begin
        st0 = 1'b1;
        d0  = mid_w;
      end else if (n == mid_n + 1) begin
        st0 = 1'b0;
      end
      if (n == late_n) begin
        st0 = 1'b1;
        d0  = late_w;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if ({sclk0, sdo0, lat0, busy0, done0} !== 5'b00100) begin
        n_fail++;
        $display("FAIL reset_u0 cyc %0d: got %b want 00100", i,
                 {sclk0, sdo0, lat0, busy0, done0});
      end
      n_chk++;
      if ({sclk1, sdo1, lat1, busy1, done1} !== 5'b00100) begin
        n_fail++;
        $display("FAIL reset_u1 cyc %0d: got %b want 00100", i,
                 {sclk1, sdo1, lat1, busy1, done1});
      end
    end
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
    n_chk++;
    if (rx0 !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_rx: got %h want 0000", rx0);
    end
`endif
  endtask

  task automatic test_msb_first;
    int n, low, bsy, r, v;
    r = rise0;
    v = viol0;
    run0(16'hA5C3, -5, 16'h0, -5, 16'h0, n, low, bsy);
    n_chk++;
    if (n !== 32) begin
      n_fail++; $display("FAIL msb_latency: got %0d want 32", n);
    end
    n_chk++;
    if (rise0 - r !== 16) begin
      n_fail++; $display("FAIL msb_rises: got %0d want 16", rise0 - r);
    end
    n_chk++;
    if (mon0 !== 16'hA5C3) begin
      n_fail++; $display("FAIL msb_bits: got %h want a5c3", mon0);
    end
    n_chk++;
    if (low !== 32 || bsy !== 32) begin
      n_fail++;
      $display("FAIL msb_low_busy: got %0d/%0d want 32/32", low, bsy);
    end
    n_chk++;
    if ({lat0, busy0, sclk0, sdo0} !== 4'b1000) begin
      n_fail++;
      $display("FAIL msb_done_state: got %b want 1000",
               {lat0, busy0, sclk0, sdo0});
    end
    n_chk++;
    if (viol0 !== v) begin
      n_fail++; $display("FAIL msb_setup: got %0d want %0d", viol0, v);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (done0 !== 1'b0 || lat0 !== 1'b1) begin
      n_fail++;
      $display("FAIL msb_done_pulse: got %b%b want 01", done0, lat0);
    end
  endtask

  task automatic test_lsb_first;
    int n, low, hi, fh, r;
    r = rise1;
    @(negedge clk);
    d1  = 8'h01;
    st1 = 1'b1;
    @(posedge clk);
    #1;
    st1 = 1'b0;
    d1  = 8'hFE;
    n = 0; low = 0; hi = 0; fh = -1;
    while (!done1 && n < 400) begin
      if (!lat1) low++;
      if (sclk1) hi++;
      if (sclk1 && fh < 0) fh = n;
      @(posedge clk);
      #1;
      n++;
    end
    n_chk++;
    if (n !== 48) begin
      n_fail++; $display("FAIL lsb_latency: got %0d want 48", n);
    end
    n_chk++;
    if (mon1 !== 8'h80 || rise1 - r !== 8) begin
      n_fail++;
      $display("FAIL lsb_bits: got %h/%0d want 80/8", mon1, rise1 - r);
    end
    n_chk++;
    if (fh !== 3 || hi !== 24 || low !== 48) begin
      n_fail++;
      $display("FAIL lsb_phases: got %0d/%0d/%0d want 3/24/48",
               fh, hi, low);
    end
    n_chk++;
    if (viol1 !== 0 || lat1 !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_end: got %0d/%b want 0/1", viol1, lat1);
    end
  endtask

  task automatic test_back_to_back;
    int n, low, bsy, m;
    run0(16'h00FF, 10, 16'hFFFF, 31, 16'h3C5A, n, low, bsy);
    n_chk++;
    if (n !== 32 || mon0 !== 16'h00FF) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d/%h want 32/00ff", n, mon0);
    end
    n_chk++;
    if (lat0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_latch_hi: got %b want 1", lat0);
    end
    @(posedge clk);
    #1;
    st0 = 1'b0;
    d0  = 16'h0;
    n_chk++;
    if ({lat0, busy0, done0} !== 3'b010) begin
      n_fail++;
      $display("FAIL b2b_accept: got %b want 010", {lat0, busy0, done0});
    end
    m = 0;
    while (!done0 && m < 400) begin
      @(posedge clk);
      #1;
      m++;
    end
    n_chk++;
    if (m !== 32 || mon0 !== 16'h3C5A) begin
      n_fail++;
      $display("FAIL b2b_second: got %0d/%h want 32/3c5a", m, mon0);
    end
  endtask

  task automatic test_mid_reset;
    int n, low, bsy, r;
    r = rise0;
    @(negedge clk);
    d0  = 16'hF0F0;
    st0 = 1'b1;
    @(posedge clk);
    #1;
    st0 = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    n_chk++;
    if (rise0 - r !== 6 || sclk0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pos: got %0d/%b want 6/1", rise0 - r, sclk0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_chk++;
    if ({sclk0, sdo0, lat0, busy0, done0} !== 5'b00100) begin
      n_fail++;
      $display("FAIL midrst_out: got %b want 00100",
               {sclk0, sdo0, lat0, busy0, done0});
    end
    r = rise0;
    run0(16'h8001, -5, 16'h0, -5, 16'h0, n, low, bsy);
    n_chk++;
    if (n !== 32 || mon0 !== 16'h8001 || rise0 - r !== 16) begin
      n_fail++;
      $display("FAIL midrst_next: got %0d/%h/%0d want 32/8001/16",
               n, mon0, rise0 - r);
    end
  endtask

`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
  task automatic test_capture;
    int n, low, bsy;
    run0(16'h1234, -5, 16'h0, -5, 16'h0, n, low, bsy);
    run0(16'h1234, -5, 16'h0, -5, 16'h0, n, low, bsy);
    n_chk++;
    if (n !== 32 || rx0 !== 16'h1234) begin
      n_fail++;
      $display("FAIL capture: got %0d/%h want 32/1234", n, rx0);
    end
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (rx0 !== 16'h1234) begin
      n_fail++; $display("FAIL capture_hold: got %h want 1234", rx0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_mid_reset();
`ifdef SHIFTOUT_CHAIN_CAPTURE_EN
    test_capture();
`endif
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
